// File: rtl/sram_word_adapter_pkg.sv
// Shared types and constants for the word-to-byte SRAM adapter.
// Widths here must match the 4096x8 SRAM wrapper.
package sram_word_adapter_pkg;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);
  localparam int WORD_W     = DATA_W * WORD_BYTES;

  typedef logic [LANE_W-1:0]     lane_t;
  typedef logic [WORD_BYTES-1:0] mask_t;
  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [DATA_W-1:0]     byte_t;
  typedef logic [WORD_W-1:0]     word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic addr_t word_base(addr_t a);
    return {a[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  endfunction

  // Lane replaces the low bits, so a word never carries into the next one.
  function automatic addr_t lane_addr(addr_t a, lane_t l);
    return {a[ADDR_W-1:LANE_W], l};
  endfunction

  function automatic byte_t word_byte(word_t w, lane_t l);
    return w[int'(l)*DATA_W +: DATA_W];
  endfunction

  function automatic logic misaligned(addr_t a);
    return a[LANE_W-1:0] != '0;
  endfunction

endpackage

// File: rtl/sram_word_adapter_if.sv
// Core-side request/response bus plus SRAM wrapper pins.
// slave = adapter view, master = environment view.
interface sram_word_adapter_if;
  import sram_word_adapter_pkg::*;

  logic  req_valid;
  logic  req_ready;
  logic  req_we;
  addr_t req_addr;
  mask_t req_be;
  word_t req_wdata;

  logic  resp_valid;
  logic  resp_ready;
  word_t resp_rdata;
  logic  resp_err;

  logic  cs;
  logic  wen;
  addr_t addressBus;
  byte_t memDataIN;
  logic  memReady;
  byte_t memDataOut;

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_we,
    input  req_addr,
    input  req_be,
    input  req_wdata,
    output resp_valid,
    input  resp_ready,
    output resp_rdata,
    output resp_err,
    output cs,
    output wen,
    output addressBus,
    output memDataIN,
    input  memReady,
    input  memDataOut
  );

  modport master (
    output req_valid,
    input  req_ready,
    output req_we,
    output req_addr,
    output req_be,
    output req_wdata,
    input  resp_valid,
    output resp_ready,
    input  resp_rdata,
    input  resp_err,
    input  cs,
    input  wen,
    input  addressBus,
    input  memDataIN,
    output memReady,
    output memDataOut
  );

endinterface

// File: rtl/sram_lane_picker.sv
// Finds the next enabled byte lane at/after the current one.
// last_o says no enabled lane remains beyond next_o.
module sram_lane_picker
  import sram_word_adapter_pkg::*;
(
  input  mask_t mask_i,
  input  lane_t lane_i,
  input  logic  incl_i,
  output lane_t next_o,
  output logic  found_o,
  output logic  last_o
);

  // Ascending priority scan; incl_i lets the current lane qualify.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    last_o  = 1'b1;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (mask_i[i] &&
          ((lane_t'(i) > lane_i) ||
           (incl_i && (lane_t'(i) == lane_i)))) begin
        if (!found_o) begin
          next_o  = lane_t'(i);
          found_o = 1'b1;
        end else begin
          last_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sram_word_adapter.sv
// Splits 32-bit word requests into byte beats on the SRAM wrapper
// and returns one assembled response per request.
module sram_word_adapter
  import sram_word_adapter_pkg::*;
(
  input logic clk,
  input logic rst,
  sram_word_adapter_if.slave bus
);

  state_e state_q, state_d;
  logic   we_q, we_d;
  addr_t  base_q, base_d;
  mask_t  mask_q, mask_d;
  word_t  wdata_q, wdata_d;
  word_t  rdata_q, rdata_d;
  logic   err_q, err_d;
  lane_t  lane_q, lane_d;
  logic   last_q, last_d;
  logic   cs_q, cs_d;
  logic   wen_q, wen_d;
  addr_t  abus_q, abus_d;
  byte_t  dout_q, dout_d;

  mask_t  pick_mask;
  lane_t  pick_lane;
  logic   pick_incl;
  lane_t  pick_next;
  logic   pick_found;
  logic   pick_last;

  sram_lane_picker u_pick (
    .mask_i  (pick_mask),
    .lane_i  (pick_lane),
    .incl_i  (pick_incl),
    .next_o  (pick_next),
    .found_o (pick_found),
    .last_o  (pick_last)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.cs         = cs_q;
  assign bus.wen        = wen_q;
  assign bus.addressBus = abus_q;
  assign bus.memDataIN  = dout_q;

  // Next-state, beat sequencing and SRAM pin updates.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    base_d    = base_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    lane_d    = lane_q;
    last_d    = last_q;
    cs_d      = cs_q;
    wen_d     = wen_q;
    abus_d    = abus_q;
    dout_d    = dout_q;
    pick_mask = mask_q;
    pick_lane = lane_q;
    pick_incl = 1'b0;

    unique case (state_q)
      IDLE: begin
        pick_mask = bus.req_we ? bus.req_be : '1;
        pick_lane = '0;
        pick_incl = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          base_d  = word_base(bus.req_addr);
          mask_d  = pick_mask;
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (misaligned(bus.req_addr)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (!pick_found) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            lane_d  = pick_next;
            last_d  = pick_last;
            cs_d    = 1'b1;
            wen_d   = bus.req_we;
            abus_d  = lane_addr(bus.req_addr, pick_next);
            dout_d  = word_byte(bus.req_wdata, pick_next);
          end
        end
      end
      ACCESS: begin
        if (bus.memReady) begin
          if (!we_q) begin
            rdata_d[int'(lane_q)*DATA_W +: DATA_W] = bus.memDataOut;
          end
          if (last_q) begin
            state_d = RESP;
            cs_d    = 1'b0;
            wen_d   = 1'b0;
          end else begin
            lane_d = pick_next;
            last_d = pick_last;
            abus_d = lane_addr(base_q, pick_next);
            dout_d = word_byte(wdata_q, pick_next);
          end
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        wen_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      base_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      lane_q  <= '0;
      last_q  <= 1'b0;
      cs_q    <= 1'b0;
      wen_q   <= 1'b0;
      abus_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
      cs_q    <= cs_d;
      wen_q   <= wen_d;
      abus_q  <= abus_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_sram_word_adapter.sv
// Bench for sram_word_adapter with a 2-cycle-beat SRAM model
// and a scoreboard of expected word responses.
module tb_sram_word_adapter;
  import sram_word_adapter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_word_adapter_if bus();

  sram_word_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          beats;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem[4096];
  logic [7:0]  ref_mem[4096];
  logic        rdy;
  int          cs_cyc;
  logic [11:0] seen_q[$];

  int vectors;
  int miscompares;

  logic [31:0] got_rdata;
  logic        got_err;
  int          got_lat;
  int          cs0;
  int          sq0;

  assign bus.memReady = rdy;

  // SRAM wrapper model: ready one cycle after cs, op on the ready edge.
  always @(posedge clk) begin
    if (rst) begin
      rdy <= 1'b0;
    end else if (bus.cs && !rdy) begin
      rdy <= 1'b1;
      bus.memDataOut <= mem[bus.addressBus];
    end else begin
      rdy <= 1'b0;
      if (bus.cs && bus.wen && rdy) mem[bus.addressBus] <= bus.memDataIN;
    end
  end

  // Bus monitor: cs-high cycles and the address of each completed beat.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.cs) cs_cyc++;
      if (bus.cs && bus.memReady) seen_q.push_back(bus.addressBus);
    end
  end

  function automatic exp_t model(logic we, logic [11:0] a,
                                 logic [3:0] be, logic [31:0] wd);
    exp_t e;
    e.rdata = '0;
    e.err   = 1'b0;
    e.beats = 0;
    e.lat   = 1;
    if (a[1:0] != 2'b00) begin
      e.err = 1'b1;
      return e;
    end
    for (int i = 0; i < 4; i++) begin
      if (we) begin
        if (be[i]) begin
          ref_mem[{a[11:2], 2'(i)}] = wd[8*i +: 8];
          e.beats++;
        end
      end else begin
        e.rdata[8*i +: 8] = ref_mem[{a[11:2], 2'(i)}];
        e.beats++;
      end
    end
    e.lat = 2 * e.beats + 1;
    return e;
  endfunction

  function automatic logic [47:0] trace(int from);
    logic [47:0] t = '0;
    for (int k = 0; k < 4; k++) begin
      if (from + k < seen_q.size()) t[47-12*k -: 12] = seen_q[from+k];
    end
    return t;
  endfunction

  task automatic issue(logic we, logic [11:0] a,
                       logic [3:0] be, logic [31:0] wd);
    cs0 = cs_cyc;
    sq0 = seen_q.size();
    exp_q.push_back(model(we, a, be, wd));
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_be    = be;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic collect();
    got_lat = 1;
    while (!bus.resp_valid && got_lat < 40) begin
      @(negedge clk);
      got_lat++;
    end
    got_rdata = bus.resp_rdata;
    got_err   = bus.resp_err;
  endtask

  task automatic ack();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.cs, bus.wen}
        !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctl got %b want 10000",
               {bus.req_ready, bus.resp_valid, bus.resp_err, bus.cs, bus.wen});
    end
    vectors++;
    if ({bus.addressBus, bus.memDataIN, bus.resp_rdata} !== 52'h0) begin
      miscompares++;
      $display("FAIL reset_data got %h want 0",
               {bus.addressBus, bus.memDataIN, bus.resp_rdata});
    end
  endtask

  task automatic test_full_word();
    exp_t e;
    issue(1'b1, 12'h010, 4'hF, 32'hA1B2C3D4);
    collect();
    ack();
    e = exp_q.pop_front();
    vectors++;
    if (got_lat !== e.lat || seen_q.size() - sq0 !== e.beats) begin
      miscompares++;
      $display("FAIL wr_full lat/beats got %0d/%0d want %0d/%0d",
               got_lat, seen_q.size() - sq0, e.lat, e.beats);
    end
    issue(1'b0, 12'h010, 4'h0, 32'h0);
    collect();
    ack();
    e = exp_q.pop_front();
    vectors++;
    if ({got_rdata, got_err} !== {e.rdata, e.err}) begin
      miscompares++;
      $display("FAIL rd_full data got %h/%b want %h/%b",
               got_rdata, got_err, e.rdata, e.err);
    end
    vectors++;
    if (got_lat !== 9 || cs_cyc - cs0 !== 2 * e.beats) begin
      miscompares++;
      $display("FAIL rd_full lat/cs got %0d/%0d want 9/%0d",
               got_lat, cs_cyc - cs0, 2 * e.beats);
    end
    vectors++;
    if (trace(sq0) !== {12'h010, 12'h011, 12'h012, 12'h013}) begin
      miscompares++;
      $display("FAIL rd_full addrs got %h want 010011012013", trace(sq0));
    end
  endtask

  task automatic test_partial();
    exp_t e;
    issue(1'b1, 12'h010, 4'b0101, 32'h11223344);
    collect();
    ack();
    e = exp_q.pop_front();
    vectors++;
    if (got_lat !== e.lat || got_lat !== 5) begin
      miscompares++;
      $display("FAIL wr_part lat got %0d want %0d", got_lat, e.lat);
    end
    vectors++;
    if (trace(sq0) !== {12'h010, 12'h012, 24'h0}) begin
      miscompares++;
      $display("FAIL wr_part addrs got %h want 010012000000", trace(sq0));
    end
    issue(1'b0, 12'h010, 4'h0, 32'h0);
    collect();
    ack();
    e = exp_q.pop_front();
    vectors++;
    if ({got_rdata, got_err} !== {e.rdata, e.err} ||
        got_rdata !== 32'hA122C344) begin
      miscompares++;
      $display("FAIL rd_part data got %h want %h", got_rdata, e.rdata);
    end
  endtask

  task automatic test_no_access();
    exp_t e;
    issue(1'b0, 12'h013, 4'h0, 32'h0);
    collect();
    ack();
    e = exp_q.pop_front();
    vectors++;
    if ({got_rdata, got_err} !== {e.rdata, e.err} ||
        got_lat !== e.lat || cs_cyc != cs0) begin
      miscompares++;
      $display("FAIL misalign got %h/%b lat %0d cs %0d want %h/%b lat %0d cs 0",
               got_rdata, got_err, got_lat, cs_cyc - cs0,
               e.rdata, e.err, e.lat);
    end
    vectors++;
    if (bus.resp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign clear got err %b rdy %b want 0 1",
               bus.resp_err, bus.req_ready);
    end
    issue(1'b1, 12'h020, 4'h0, 32'hFFFF_FFFF);
    collect();
    ack();
    e = exp_q.pop_front();
    vectors++;
    if ({got_rdata, got_err} !== {e.rdata, e.err} ||
        got_lat !== e.lat || cs_cyc != cs0) begin
      miscompares++;
      $display("FAIL be0 got %h/%b lat %0d cs %0d want %h/%b lat %0d cs 0",
               got_rdata, got_err, got_lat, cs_cyc - cs0,
               e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_top_word();
    exp_t e;
    issue(1'b1, 12'hFFC, 4'hF, 32'hDEADBEEF);
    collect();
    ack();
    e = exp_q.pop_front();
    vectors++;
    if (got_lat !== e.lat || trace(sq0) !== {12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF}) begin
      miscompares++;
      $display("FAIL wr_top lat %0d addrs %h want %0d FFCFFDFFEFFF",
               got_lat, trace(sq0), e.lat);
    end
    issue(1'b0, 12'hFFC, 4'h0, 32'h0);
    collect();
    ack();
    e = exp_q.pop_front();
    vectors++;
    if (trace(sq0) !== {12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF}) begin
      miscompares++;
      $display("FAIL rd_top addrs got %h want FFCFFDFFEFFF", trace(sq0));
    end
    vectors++;
    if ({got_rdata, got_err} !== {e.rdata, e.err} ||
        got_rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL rd_top data got %h want %h", got_rdata, e.rdata);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   cs_hold;
    issue(1'b0, 12'h010, 4'h0, 32'h0);
    collect();
    e = exp_q.pop_front();
    vectors++;
    if (got_lat !== e.lat) begin
      miscompares++;
      $display("FAIL bp lat got %0d want %0d", got_lat, e.lat);
    end
    bus.req_we    = 1'b0;
    bus.req_addr  = 12'h020;
    bus.req_valid = 1'b1;
    cs_hold = cs_cyc;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus.resp_valid, bus.req_ready, bus.resp_rdata} !==
          {1'b1, 1'b0, e.rdata}) begin
        miscompares++;
        $display("FAIL bp_hold%0d got %b %b %h want 1 0 %h", c,
                 bus.resp_valid, bus.req_ready, bus.resp_rdata, e.rdata);
      end
    end
    bus.req_valid = 1'b0;
    vectors++;
    if (cs_cyc != cs_hold) begin
      miscompares++;
      $display("FAIL bp_noaccept got %0d cs cycles want 0", cs_cyc - cs_hold);
    end
    ack();
    vectors++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_done got %b%b want 01", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   spurious = 0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 12'h010;
    bus.req_be    = 4'h0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({bus.cs, bus.req_ready, bus.resp_valid} !== 3'b010) begin
      miscompares++;
      $display("FAIL rst_mid got cs/rdy/vld %b want 010",
               {bus.cs, bus.req_ready, bus.resp_valid});
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.cs) spurious++;
    end
    vectors++;
    if (spurious != 0) begin
      miscompares++;
      $display("FAIL rst_mid_quiet got %0d busy cycles want 0", spurious);
    end
    issue(1'b0, 12'h010, 4'h0, 32'h0);
    collect();
    ack();
    e = exp_q.pop_front();
    vectors++;
    if ({got_rdata, got_err} !== {e.rdata, e.err} || got_lat !== e.lat) begin
      miscompares++;
      $display("FAIL rst_after got %h/%b lat %0d want %h/%b lat %0d",
               got_rdata, got_err, got_lat, e.rdata, e.err, e.lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_be     = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_word();
    test_partial();
    test_no_access();
    test_top_word();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
